// File: rtl/dac_spi_streamer.sv
// dac_spi_streamer
//   Buffered SPI master for a 12-bit MCP4921-class DAC. Samples arrive over a
//   valid/ready handshake and are queued in a small FIFO. Each sample is sent
//   MSB first as a 16-bit frame {CONFIG_BITS, sample}.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   in_valid      sample offered this cycle
//   in_data[11:0] unsigned DAC sample
//   in_ready      registered !full; transfer = in_valid & in_ready
//   dac_csb       SPI chip select, active low
//   dac_sclk      SPI clock, idles low; the DAC samples DIN on its rising edge
//   dac_din       SPI data; changes only on SCLK falling edges or while CSB is high
//   busy          FIFO not empty, or a frame/gap in progress
//   frame_done    one-cycle pulse in the cycle dac_csb returns high
//   overrun       sticky flag; an offer arrived while in_ready was low
//   dac_ldac_n    (only with DAC_LDAC_EN) LDAC strobe, low CLK_DIV cycles in the gap
//
// Build option
//   DAC_LDAC_EN   adds dac_ldac_n and pulses it during the inter-frame gap.
module dac_spi_streamer #(
    parameter int         CLK_DIV     = 16,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [3:0] CONFIG_BITS = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        in_ready,
    output logic        dac_csb,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done,
`ifdef DAC_LDAC_EN
    output logic        dac_ldac_n,
`endif
    output logic        overrun
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state_q, state_d;
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          overrun_q, overrun_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic          gap_cnt_q, gap_cnt_d;
    logic          csb_q, csb_d, sclk_q, sclk_d, din_q, din_d, fdone_q, fdone_d;
`ifdef DAC_LDAC_EN
    logic          ldac_n_q, ldac_n_d;
`endif
    logic          push, pop, tick;

    // FIFO bookkeeping and SCLK prescaler
    always_comb begin
        push       = in_valid & in_ready_q;
        pop        = (state_q == IDLE) && (count_q != '0);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        // in_ready is registered from the next occupancy, so a pop frees a
        // slot only one cycle later and never feeds back combinationally.
        in_ready_d = (count_d != FIFO_FULL);
        overrun_d  = overrun_q | (in_valid & ~in_ready_q);
        tick       = (state_q != IDLE) && (pre_q == PRE_LAST);
        pre_d      = ((state_q == IDLE) || tick) ? '0 : pre_q + 1'b1;
    end

    // Frame sequencer
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        gap_cnt_d = gap_cnt_q;
        csb_d     = csb_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        fdone_d   = 1'b0;
`ifdef DAC_LDAC_EN
        ldac_n_d  = ldac_n_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shreg_d  = {CONFIG_BITS, mem_q[rd_ptr_q]};
                    csb_d    = 1'b0;
                    din_d    = CONFIG_BITS[3];
                    bitcnt_d = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bitcnt_q < 5'd15) begin
                            shreg_d  = shreg_q << 1;
                            din_d    = shreg_q[14];
                            bitcnt_d = bitcnt_q + 5'd1;
                        end else begin
                            bitcnt_d = 5'd16;
                        end
                    end else if (bitcnt_q == 5'd16) begin
                        // CSB is held low one half-period past the last
                        // falling edge so the DAC sees a clean CS hold time.
                        csb_d     = 1'b1;
                        fdone_d   = 1'b1;
                        din_d     = 1'b0;
                        gap_cnt_d = 1'b0;
                        state_d   = GAP;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            GAP: begin
                din_d = 1'b0;
                if (tick) begin
                    if (gap_cnt_q) begin
                        state_d = IDLE;
`ifdef DAC_LDAC_EN
                        ldac_n_d = 1'b1;
`endif
                    end else begin
                        gap_cnt_d = 1'b1;
`ifdef DAC_LDAC_EN
                        ldac_n_d = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            pre_q      <= '0;
            bitcnt_q   <= '0;
            gap_cnt_q  <= 1'b0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            din_q      <= 1'b0;
            fdone_q    <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            overrun_q  <= overrun_d;
            pre_q      <= pre_d;
            bitcnt_q   <= bitcnt_d;
            gap_cnt_q  <= gap_cnt_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            din_q      <= din_d;
            fdone_q    <= fdone_d;
`ifdef DAC_LDAC_EN
            ldac_n_q   <= ldac_n_d;
`endif
        end
    end

    // Sample storage and shift register carry no reset; control gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
        shreg_q <= shreg_d;
    end

    assign in_ready   = in_ready_q;
    assign overrun    = overrun_q;
    assign dac_csb    = csb_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign frame_done = fdone_q;
    assign busy       = (count_q != '0) || (state_q != IDLE);
`ifdef DAC_LDAC_EN
    assign dac_ldac_n = ldac_n_q;
`endif

endmodule
